// File: rtl/aes_job_arbiter.sv
// Round-robin front end that shares a single AES_top core among NUM_REQ requesters,
// with a watchdog that flushes the core when no result arrives in time.
module aes_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   core_rst_n,
  output logic                   core_en,
  output logic [127:0]           core_data_in,
  output logic [127:0]           core_key_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_data_out_valid
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic [127:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rst_hold_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [127:0]    grant_data, grant_key;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && cand == i && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
    grant_data = '0;
    grant_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data = req_data[128*i +: 128];
        grant_key  = req_key[128*i +: 128];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
    core_en      = 1'b0;
    rsp_valid    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found && !AES_rst) begin
          req_ready    = NUM_REQ'(1) << grant_idx;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          data_d       = grant_data;
          key_d        = grant_key;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        core_en = 1'b1;
        if (core_data_out_valid) begin
          rsp_data_d = core_data_out;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          flush_d    = 1'b0;
          state_d    = S_FLUSH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    // NOTE: non-blocking assignments so all registers update together at the edge.
    if (AES_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      data_q       <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Stretches the core reset one cycle past the release of AES_rst.
  always_ff @(posedge AES_clk) begin
    rst_hold_q <= AES_rst;
  end

  assign core_rst_n   = !(AES_rst || rst_hold_q || state_q == S_FLUSH);
  assign busy         = (state_q != S_IDLE);
  assign rsp_id       = id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign core_data_in = data_q;
  assign core_key_in  = key_q;

endmodule
